requant_output_writer: RTL and testbench
========================================

Name: requant_output_writer

Overview:
- Sits directly downstream of the requantize controller.
- Takes its per-lane int8 outputs (valid/row/col/data per SA lane) and packs column-adjacent bytes into 32-bit words per lane.
- Buffers completed words in per-lane FIFOs, then drains them round-robin to the single activation-SRAM write port with byte enables.
- A flush handshake pushes partial words at layer end and reports completion.

Parameters:
- SA_N, 4, number of input lanes (one per output channel of the array)
- MAX_N, 16, max rows/cols of an output tile
- N_BITS, $clog2(MAX_N), row/col index width
- ADDR_WIDTH, 16, SRAM word-address width
- FIFO_DEPTH, 8, entries per lane FIFO (power of two)

Ports:
- clk  in  1  clock
- reset  in  1  reset
- cfg_valid  in  1  latch cfg_* and clear overflow
- cfg_base_addr  in  ADDR_WIDTH  layer output base word address
- cfg_row_stride  in  ADDR_WIDTH  words per output row
- cfg_ch_stride  in  ADDR_WIDTH  words per lane/channel plane
- in_valid  in  [SA_N] x 1  byte valid per lane
- in_row  in  [SA_N] x N_BITS  row index
- in_col  in  [SA_N] x N_BITS  col index
- in_data  in  [SA_N] x int8_t  requantized byte
- flush  in  1  pulse: drain everything, layer done
- flush_done  out  1  one-cycle pulse when flush completes
- busy  out  1  any packer/FIFO non-empty or mem_we high
- overflow  out  1  sticky: a word was dropped
- mem_we  out  1  write request
- mem_addr  out  ADDR_WIDTH  word address
- mem_wdata  out  32  write data
- mem_be  out  4  byte enables
- mem_ready  in  1  SRAM accepts write this cycle

Behaviour:
- Reset is asynchronous, active-high, on clock clk.
- Reset clears every output, all packers, FIFOs, cfg registers, arbiter pointer (lane 0) and FSM (RUN). Reset mid-transfer abandons the pending write; no resumption.
- No upstream backpressure: in_valid is accepted every cycle on all lanes.
- Per-lane packer holds word, mask[3:0], row, cword = col>>2.
  - Byte position = col[1:0]; byte 0 is LSB.
  - Packer empty: load new byte, set mask bit.
  - Packer non-empty, same (row, cword): write byte and set mask bit. A duplicate position overwrites data; mask unchanged.
  - Different (row, cword): push the old word to the FIFO and start a new word in the same cycle.
  - Mask reaching 4'hF: push the word that cycle; packer becomes empty.
- Push computes addr = cfg_base_addr + lane*cfg_ch_stride + row*cfg_row_stride + cword, truncated mod 2^ADDR_WIDTH, using cfg values current at push. The FIFO entry is {addr, data, be = mask}.
- Push into a full FIFO drops the entry and sets overflow. Overflow stays set until reset or cfg_valid.
- cfg_valid while busy affects only later pushes.
- Drain:
  - The round-robin arbiter starts at the lane after the last granted lane and picks the first non-empty FIFO.
  - mem_we/addr/wdata/be are registered and held stable while mem_we && !mem_ready.
  - Transfer occurs when mem_we && mem_ready. The next grant can issue the same edge, giving 1 word/cycle max.
- Latency, idle port: byte completing a word sampled at edge E0 → FIFO at E0 → mem_we high after E1.
- FSM:
  - RUN --flush--> FLUSH. On the flush cycle, same-cycle in_valid bytes are merged first, then every non-empty packer pushes its partial word (be = mask).
  - FLUSH stays until all FIFOs are empty and mem_we is low, then asserts flush_done for 1 cycle → RUN.
  - flush while in FLUSH is ignored.
  - in_valid during FLUSH is packed normally but not force-pushed; flush_done does not wait for it.
- Simultaneous FIFO push and pop on the same lane is legal. A full FIFO with a pop that same cycle accepts the push (no overflow).

Test Plan:
- cfg base=0x100, row_stride=4, ch_stride=0x40. Lane0 row2 cols0..3 data 0x11,0x22,0x33,0x44 on consecutive cycles, mem_ready=1 → one write: addr 0x108, wdata 0x44332211, be 4'hF, mem_we high 2 cycles after last byte.
- Lane1 row0 col5 data 0xAB, then flush → write addr 0x141, wdata byte1=0xAB, be 4'b0010; flush_done pulses once after mem_we drops.
- Lane0 row0 cols0,1 then row1 col0 → partial write addr 0x100 be 4'b0011 pushed at row change; row1 word remains pending until flush (addr 0x104, be 4'b0001).
- All 4 lanes complete a word the same cycle, mem_ready low 5 cycles → mem outputs hold stable; after release, grants lanes 0,1,2,3 in order, one per cycle.
- mem_ready=0, lane2 pushes 9 full words → overflow=1 on the 9th, 8 writes drain afterward; cfg_valid clears overflow.
- Assert reset while mem_we high with FIFOs non-empty → all outputs 0 next cycle, busy=0, no further writes.

Source files
------------

// File: rtl/requant_output_writer.sv
// Packs per-lane requantized int8 bytes into 32-bit words, buffers them in per-lane FIFOs
// and drains them round-robin to a single activation-SRAM write port with byte enables.

module requant_lane #(
    parameter int LANE       = 0,
    parameter int N_BITS     = 4,
    parameter int ADDR_WIDTH = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [N_BITS-1:0]     in_row,
    input  logic [N_BITS-1:0]     in_col,
    input  logic [7:0]            in_data,
    input  logic                  force_push,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH-1:0] row_stride,
    input  logic [ADDR_WIDTH-1:0] ch_stride,
    input  logic                  pop,
    output logic                  pk_busy,
    output logic                  fifo_nempty,
    output logic                  drop,
    output logic [ADDR_WIDTH-1:0] head_addr,
    output logic [31:0]           head_data,
    output logic [3:0]            head_be
);
    localparam int CW = N_BITS - 2;
    localparam int PW = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [31:0]           data;
        logic [3:0]            be;
    } entry_t;

    logic              pk_valid;
    logic [31:0]       pk_word;
    logic [3:0]        pk_mask;
    logic [N_BITS-1:0] pk_row;
    logic [CW-1:0]     pk_cword;

    logic              nxt_valid;
    logic [31:0]       nxt_word, m_word;
    logic [3:0]        nxt_mask, m_mask;
    logic [N_BITS-1:0] nxt_row;
    logic [CW-1:0]     nxt_cword;

    logic [CW-1:0]     in_cword;
    logic [1:0]        bpos;
    logic              same;

    // Slot a carries the evicted word, slot b the word completed or flushed this cycle.
    logic              push_a, push_b;
    logic [N_BITS-1:0] row_a, row_b;
    logic [CW-1:0]     cw_a, cw_b;
    logic [31:0]       data_a, data_b;
    logic [3:0]        be_a, be_b;

    assign in_cword = in_col[N_BITS-1:2];
    assign bpos     = in_col[1:0];
    assign same     = pk_valid && (pk_row == in_row) && (pk_cword == in_cword);

    always_comb begin
        push_a    = 1'b0;
        row_a     = pk_row;
        cw_a      = pk_cword;
        data_a    = pk_word;
        be_a      = pk_mask;
        push_b    = 1'b0;
        row_b     = in_row;
        cw_b      = in_cword;
        data_b    = pk_word;
        be_b      = pk_mask;
        nxt_valid = pk_valid;
        nxt_word  = pk_word;
        nxt_mask  = pk_mask;
        nxt_row   = pk_row;
        nxt_cword = pk_cword;
        m_word    = same ? pk_word : '0;
        m_mask    = same ? pk_mask : '0;
        m_word[{bpos, 3'b000} +: 8] = in_data;
        m_mask[bpos] = 1'b1;
        if (in_valid) begin
            push_a = pk_valid && !same;
            if (m_mask == 4'hF || force_push) begin
                push_b    = 1'b1;
                data_b    = m_word;
                be_b      = m_mask;
                nxt_valid = 1'b0;
            end else begin
                nxt_valid = 1'b1;
                nxt_word  = m_word;
                nxt_mask  = m_mask;
                nxt_row   = in_row;
                nxt_cword = in_cword;
            end
        end else if (force_push && pk_valid) begin
            push_b    = 1'b1;
            row_b     = pk_row;
            cw_b      = pk_cword;
            nxt_valid = 1'b0;
        end
    end

    logic [ADDR_WIDTH-1:0] lane_off, addr_a, addr_b;
    assign lane_off = ADDR_WIDTH'(LANE) * ch_stride;
    assign addr_a   = base_addr + lane_off + ADDR_WIDTH'(row_a) * row_stride + ADDR_WIDTH'(cw_a);
    assign addr_b   = base_addr + lane_off + ADDR_WIDTH'(row_b) * row_stride + ADDR_WIDTH'(cw_b);

    entry_t          fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [PW:0]     count;
    logic [PW+1:0]   free;
    logic            acc_a, acc_b, do_pop;

    // A pop in the same cycle frees a slot, so a full FIFO can still take a push.
    assign do_pop = pop && (count != '0);
    assign free   = (PW+2)'(FIFO_DEPTH) - {1'b0, count} + (PW+2)'(do_pop);
    assign acc_a  = push_a && (free != '0);
    assign acc_b  = push_b && (free > (PW+2)'(acc_a));
    assign drop   = (push_a && !acc_a) || (push_b && !acc_b);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pk_valid <= 1'b0;
            pk_word  <= '0;
            pk_mask  <= '0;
            pk_row   <= '0;
            pk_cword <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            pk_valid <= nxt_valid;
            pk_word  <= nxt_word;
            pk_mask  <= nxt_mask;
            pk_row   <= nxt_row;
            pk_cword <= nxt_cword;
            wr_ptr   <= wr_ptr + PW'(acc_a) + PW'(acc_b);
            rd_ptr   <= rd_ptr + PW'(do_pop);
            count    <= count + (PW+1)'(acc_a) + (PW+1)'(acc_b) - (PW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (acc_a) fifo_mem[wr_ptr] <= '{addr_a, data_a, be_a};
        if (acc_b) fifo_mem[wr_ptr + PW'(acc_a)] <= '{addr_b, data_b, be_b};
    end

    assign head_addr   = fifo_mem[rd_ptr].addr;
    assign head_data   = fifo_mem[rd_ptr].data;
    assign head_be     = fifo_mem[rd_ptr].be;
    assign fifo_nempty = (count != '0);
    assign pk_busy     = pk_valid;
endmodule

module requant_output_writer #(
    parameter int SA_N       = 4,
    parameter int MAX_N      = 16,
    parameter int N_BITS     = $clog2(MAX_N),
    parameter int ADDR_WIDTH = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          cfg_valid,
    input  logic [ADDR_WIDTH-1:0]         cfg_base_addr,
    input  logic [ADDR_WIDTH-1:0]         cfg_row_stride,
    input  logic [ADDR_WIDTH-1:0]         cfg_ch_stride,
    input  logic [SA_N-1:0]               in_valid,
    input  logic [SA_N-1:0][N_BITS-1:0]   in_row,
    input  logic [SA_N-1:0][N_BITS-1:0]   in_col,
    input  logic [SA_N-1:0][7:0]          in_data,
    input  logic                          flush,
    output logic                          flush_done,
    output logic                          busy,
    output logic                          overflow,
    output logic                          mem_we,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    output logic [31:0]                   mem_wdata,
    output logic [3:0]                    mem_be,
    input  logic                          mem_ready
);
    localparam int LW = (SA_N > 1) ? $clog2(SA_N) : 1;

    typedef enum logic {RUN, FLUSH} state_t;

    state_t                          state;
    logic [ADDR_WIDTH-1:0]           base_q, row_stride_q, ch_stride_q;
    logic [LW-1:0]                   ptr, grant;
    logic                            grant_ok, can_issue, force_push;
    logic [SA_N-1:0]                 pk_busy, nempty, drop, pop;
    logic [SA_N-1:0][ADDR_WIDTH-1:0] head_addr;
    logic [SA_N-1:0][31:0]           head_data;
    logic [SA_N-1:0][3:0]            head_be;

    assign force_push = (state == RUN) && flush;

    for (genvar g = 0; g < SA_N; g++) begin : g_lane
        requant_lane #(
            .LANE(g), .N_BITS(N_BITS), .ADDR_WIDTH(ADDR_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)
        ) u_lane (
            .clk(clk), .reset(reset),
            .in_valid(in_valid[g]), .in_row(in_row[g]), .in_col(in_col[g]), .in_data(in_data[g]),
            .force_push(force_push),
            .base_addr(base_q), .row_stride(row_stride_q), .ch_stride(ch_stride_q),
            .pop(pop[g]),
            .pk_busy(pk_busy[g]), .fifo_nempty(nempty[g]), .drop(drop[g]),
            .head_addr(head_addr[g]), .head_data(head_data[g]), .head_be(head_be[g])
        );
    end

    // Round-robin search starting at ptr, which points one past the last grant.
    always_comb begin
        int idx;
        grant_ok = 1'b0;
        grant    = ptr;
        idx      = 0;
        for (int i = 0; i < SA_N; i++) begin
            idx = (int'(ptr) + i) % SA_N;
            if (!grant_ok && nempty[idx]) begin
                grant_ok = 1'b1;
                grant    = LW'(idx);
            end
        end
    end

    assign can_issue = !mem_we || mem_ready;
    assign pop       = (can_issue && grant_ok) ? (SA_N'(1) << grant) : '0;
    assign busy      = (|pk_busy) || (|nempty) || mem_we;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= RUN;
            base_q       <= '0;
            row_stride_q <= '0;
            ch_stride_q  <= '0;
            overflow     <= 1'b0;
            flush_done   <= 1'b0;
            ptr          <= '0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_be       <= '0;
        end else begin
            if (cfg_valid) begin
                base_q       <= cfg_base_addr;
                row_stride_q <= cfg_row_stride;
                ch_stride_q  <= cfg_ch_stride;
            end
            if (|drop)          overflow <= 1'b1;
            else if (cfg_valid) overflow <= 1'b0;

            if (can_issue) begin
                mem_we <= grant_ok;
                if (grant_ok) begin
                    mem_addr  <= head_addr[grant];
                    mem_wdata <= head_data[grant];
                    mem_be    <= head_be[grant];
                    ptr       <= (grant == LW'(SA_N - 1)) ? '0 : grant + LW'(1);
                end
            end

            flush_done <= 1'b0;
            case (state)
                RUN:   if (flush) state <= FLUSH;
                FLUSH: if (nempty == '0 && !mem_we) begin
                    flush_done <= 1'b1;
                    state      <= RUN;
                end
                default: state <= RUN;
            endcase
        end
    end
endmodule

// File: tb/tb_requant_output_writer.sv
// Scoreboard bench for requant_output_writer: directed byte streams, expected writes queued
// at stimulus time and checked by an independent monitor on every accepted SRAM write.

module tb_requant_output_writer;
    localparam int NB = 4;

    typedef struct packed {
        logic [15:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } wr_t;

    logic                clk, reset, cfg_valid, flush, mem_ready;
    logic [15:0]         cfg_base_addr, cfg_row_stride, cfg_ch_stride;
    logic [3:0]          in_valid;
    logic [3:0][NB-1:0]  in_row, in_col;
    logic [3:0][7:0]     in_data;
    logic                flush_done, busy, overflow, mem_we;
    logic [15:0]         mem_addr;
    logic [31:0]         mem_wdata;
    logic [3:0]          mem_be;

    wr_t sb[$];
    wr_t mon_e;
    int  n_chk = 0;
    int  n_fail = 0;

    requant_output_writer dut (
        .clk(clk), .reset(reset), .cfg_valid(cfg_valid),
        .cfg_base_addr(cfg_base_addr), .cfg_row_stride(cfg_row_stride), .cfg_ch_stride(cfg_ch_stride),
        .in_valid(in_valid), .in_row(in_row), .in_col(in_col), .in_data(in_data),
        .flush(flush), .flush_done(flush_done), .busy(busy), .overflow(overflow),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_ready(mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        in_valid  = '0;
        flush     = 1'b0;
        cfg_valid = 1'b0;
    endtask

    task automatic put(input int l, input int r, input int c, input logic [7:0] d);
        in_valid[l] = 1'b1;
        in_row[l]   = NB'(r);
        in_col[l]   = NB'(c);
        in_data[l]  = d;
    endtask

    task automatic expect_wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] be);
        sb.push_back('{a, d, be});
    endtask

    task automatic wait_sb(input string name);
        for (int k = 0; k < 200 && sb.size() != 0; k++) step();
        chk(name, 64'(sb.size()), 64'd0);
    endtask

    task automatic flush_wait(input string name);
        int cnt;
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (flush_done) begin
                cnt++;
                chk({name, "_we_low"}, 64'(mem_we), 64'd0);
                chk({name, "_all_written"}, 64'(sb.size()), 64'd0);
            end
        end
        chk({name, "_pulses"}, 64'(cnt), 64'd1);
    endtask

    // Monitor: every accepted write must match the oldest expected entry.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && mem_we && mem_ready) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_write: got addr 0x%0h, expected no write", mem_addr);
                end else begin
                    mon_e = sb.pop_front();
                    chk("wr_addr", 64'(mem_addr), 64'(mon_e.addr));
                    chk("wr_data", 64'(mem_wdata), 64'(mon_e.data));
                    chk("wr_be", 64'(mem_be), 64'(mon_e.be));
                end
            end
        end
    end

    initial begin
        int cnt;
        reset = 1'b1; cfg_valid = 1'b0; flush = 1'b0; mem_ready = 1'b1;
        cfg_base_addr = '0; cfg_row_stride = '0; cfg_ch_stride = '0;
        in_valid = '0; in_row = '0; in_col = '0; in_data = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_mem_we", 64'(mem_we), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_flush_done", 64'(flush_done), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);

        cfg_valid = 1'b1; cfg_base_addr = 16'h0100; cfg_row_stride = 16'd4; cfg_ch_stride = 16'h0040;
        step();

        // Full word on lane0 row2, latency from last byte.
        expect_wr(16'h0108, 32'h44332211, 4'hF);
        put(0, 2, 0, 8'h11); step();
        put(0, 2, 1, 8'h22); step();
        put(0, 2, 2, 8'h33); step();
        put(0, 2, 3, 8'h44); step();
        chk("lat_e0_we", 64'(mem_we), 64'd0);
        step();
        chk("lat_e1_we", 64'(mem_we), 64'd1);
        chk("lat_e1_addr", 64'(mem_addr), 64'h108);
        wait_sb("t1_drain");
        step();
        chk("t1_idle", 64'(busy), 64'd0);

        // Single byte then flush.
        put(1, 0, 5, 8'hAB); step();
        expect_wr(16'h0141, 32'h0000AB00, 4'b0010);
        flush = 1'b1;
        flush_wait("t2_flush");

        // Duplicate overwrite, row change eviction, flush-cycle merge and double push.
        put(0, 0, 0, 8'h01); put(3, 0, 0, 8'h77); step();
        put(0, 0, 0, 8'h09); step();
        put(0, 0, 1, 8'h02); step();
        expect_wr(16'h0100, 32'h00000209, 4'b0011);
        put(0, 1, 0, 8'h03); step();
        wait_sb("t3_evict");
        step();
        chk("t3_pending_busy", 64'(busy), 64'd1);
        chk("t3_pending_we", 64'(mem_we), 64'd0);
        expect_wr(16'h01C0, 32'h00000077, 4'b0001);
        expect_wr(16'h0104, 32'h00000403, 4'b0011);
        expect_wr(16'h01C4, 32'h00000088, 4'b0001);
        put(0, 1, 1, 8'h04); put(3, 1, 0, 8'h88); flush = 1'b1;
        flush_wait("t3_flush");

        // All lanes complete together under backpressure.
        mem_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            for (int l = 0; l < 4; l++) put(l, 0, c, 8'(l * 16 + c));
            step();
        end
        for (int l = 0; l < 4; l++)
            expect_wr(16'(16'h0100 + l * 16'h0040),
                      {8'(l * 16 + 3), 8'(l * 16 + 2), 8'(l * 16 + 1), 8'(l * 16)}, 4'hF);
        chk("t4_e0_we", 64'(mem_we), 64'd0);
        step();
        for (int k = 0; k < 5; k++) begin
            chk("t4_hold_we", 64'(mem_we), 64'd1);
            chk("t4_hold_addr", 64'(mem_addr), 64'h100);
            chk("t4_hold_data", 64'(mem_wdata), 64'h03020100);
            chk("t4_hold_be", 64'(mem_be), 64'hF);
            step();
        end
        mem_ready = 1'b1;
        step(); chk("t4_grant1", 64'(mem_addr), 64'h140);
        step(); chk("t4_grant2", 64'(mem_addr), 64'h180);
        step(); chk("t4_grant3", 64'(mem_addr), 64'h1C0);
        chk("t4_grant3_we", 64'(mem_we), 64'd1);
        step(); chk("t4_done_we", 64'(mem_we), 64'd0);
        wait_sb("t4_drain");

        // Overflow: lane0 word parks in the output register, lane2 then fills its FIFO.
        mem_ready = 1'b0;
        expect_wr(16'h0114, 32'hC3C2C1C0, 4'hF);
        for (int c = 0; c < 4; c++) begin put(0, 5, c, 8'(8'hC0 + c)); step(); end
        for (int r = 0; r < 9; r++) begin
            if (r < 8)
                expect_wr(16'(16'h0180 + r * 4),
                          {8'(r * 16 + 3), 8'(r * 16 + 2), 8'(r * 16 + 1), 8'(r * 16)}, 4'hF);
            for (int c = 0; c < 4; c++) begin put(2, r, c, 8'(r * 16 + c)); step(); end
            if (r == 7) chk("t5_no_ovf_at_8", 64'(overflow), 64'd0);
        end
        chk("t5_ovf_at_9", 64'(overflow), 64'd1);
        mem_ready = 1'b1;
        wait_sb("t5_drain");
        step();
        chk("t5_ovf_sticky", 64'(overflow), 64'd1);
        cfg_valid = 1'b1; step();
        chk("t5_ovf_clear", 64'(overflow), 64'd0);

        // Reset in the middle of a stalled transfer abandons everything.
        mem_ready = 1'b0;
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 4; c++) begin put(3, r, c, 8'(8'h50 + c)); step(); end
        step();
        chk("t6_pre_we", 64'(mem_we), 64'd1);
        chk("t6_pre_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        #1;
        chk("t6_rst_we", 64'(mem_we), 64'd0);
        chk("t6_rst_addr", 64'(mem_addr), 64'd0);
        chk("t6_rst_data", 64'(mem_wdata), 64'd0);
        chk("t6_rst_be", 64'(mem_be), 64'd0);
        chk("t6_rst_busy", 64'(busy), 64'd0);
        step();
        reset = 1'b0;
        mem_ready = 1'b1;
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (mem_we) cnt++;
        end
        chk("t6_no_writes", 64'(cnt), 64'd0);
        chk("t6_idle", 64'(busy), 64'd0);

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
